// File: rtl/vx_imem_responder.sv
// Instruction-memory responder: byte-enabled word storage with a fixed-latency read pipeline
// feeding an in-order FWFT response FIFO, throttled by an outstanding-read credit counter.
module vx_imem_responder #(
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    parameter int WORD_SIZE  = 4,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int QUEUE_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic                          req_rw,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [WORD_SIZE-1:0]          req_byteen,
    input  logic [WORD_SIZE*8-1:0]        req_data,
    input  logic [TAG_WIDTH-1:0]          req_tag,
    output logic                          req_ready,
    output logic                          rsp_valid,
    output logic [WORD_SIZE*8-1:0]        rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    input  logic                          rsp_ready,
    output logic [$clog2(QUEUE_SIZE):0]   pending
);

    localparam int DATA_W = WORD_SIZE * 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(QUEUE_SIZE);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_SIZE);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic              req_fire;
    logic              rd_fire;
    logic              wr_fire;
    logic              rsp_fire;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rdata;

    logic                 fifo_wr_valid;
    logic [DATA_W-1:0]    fifo_wr_data;
    logic [TAG_WIDTH-1:0] fifo_wr_tag;
    logic [DATA_W-1:0]    fifo_data [QUEUE_SIZE];
    logic [TAG_WIDTH-1:0] fifo_tag  [QUEUE_SIZE];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;

    // Credits are taken at issue, so a full counter also blocks writes.
    assign req_ready = (pending != CNT_FULL);
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_rw;
    assign wr_fire   = req_fire && req_rw;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign idx       = req_addr[IDX_W-1:0];
    assign mem_rdata = mem[idx];

    generate
        if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W];
        end
    endgenerate

    // Storage is intentionally outside reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < WORD_SIZE; i++) begin
                if (req_byteen[i]) begin
                    mem[idx][i*8 +: 8] <= req_data[i*8 +: 8];
                end
            end
        end
    end

    // The FIFO write is the last latency stage, so only LATENCY-1 registers sit in front of it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_wr_valid = rd_fire;
            assign fifo_wr_data  = mem_rdata;
            assign fifo_wr_tag   = req_tag;
        end else begin : g_pipe
            logic [LATENCY-2:0]   pipe_valid;
            logic [DATA_W-1:0]    pipe_data [LATENCY-1];
            logic [TAG_WIDTH-1:0] pipe_tag  [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_valid <= '0;
                end else begin
                    pipe_valid[0] <= rd_fire;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        pipe_valid[k] <= pipe_valid[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pipe_data[0] <= mem_rdata;
                pipe_tag[0]  <= req_tag;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    pipe_data[k] <= pipe_data[k-1];
                    pipe_tag[k]  <= pipe_tag[k-1];
                end
            end

            assign fifo_wr_valid = pipe_valid[LATENCY-2];
            assign fifo_wr_data  = pipe_data[LATENCY-2];
            assign fifo_wr_tag   = pipe_tag[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr_valid) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rsp_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (fifo_wr_valid && !rsp_fire) begin
                fifo_cnt <= fifo_cnt + CNT_ONE;
            end else if (!fifo_wr_valid && rsp_fire) begin
                fifo_cnt <= fifo_cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr_valid) begin
            fifo_data[wr_ptr] <= fifo_wr_data;
            fifo_tag[wr_ptr]  <= fifo_wr_tag;
        end
    end

    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_tag   = fifo_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (rd_fire && !rsp_fire) begin
            pending <= pending + CNT_ONE;
        end else if (!rd_fire && rsp_fire) begin
            pending <= pending - CNT_ONE;
        end
    end

endmodule

// File: doc/vx_imem_responder.md
VX_IMEM_RESPONDER -- requirements
Module: VX_imem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, word address width of the request.
REQ-002 SHALL have parameter TAG_WIDTH, default 8, request/response tag width; the tag is {uuid, wid}, opaque to this block.
REQ-003 SHALL have parameter WORD_SIZE, default 4, data bytes per word.
REQ-004 SHALL have parameter DEPTH, default 1024, words of storage; power of two, at least 2.
REQ-005 SHALL have parameter LATENCY, default 2, request-to-response cycles; legal range 1 to 8.
REQ-006 SHALL have parameter QUEUE_SIZE, default 4, maximum outstanding reads; power of two, at least 2.
REQ-007 SHALL have clk, input, 1, the single clock.
REQ-008 SHALL have reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have req_valid, input, 1, request present.
REQ-010 SHALL have req_rw, input, 1, 0 for read, 1 for write.
REQ-011 SHALL have req_addr, input, ADDR_WIDTH, word address.
REQ-012 SHALL have req_byteen, input, WORD_SIZE, write byte enables.
REQ-013 SHALL have req_data, input, WORD_SIZE*8, write data.
REQ-014 SHALL have req_tag, input, TAG_WIDTH, request tag.
REQ-015 SHALL have req_ready, output, 1, request accept.
REQ-016 SHALL have rsp_valid, output, 1, response present.
REQ-017 SHALL have rsp_data, output, WORD_SIZE*8, read data.
REQ-018 SHALL have rsp_tag, output, TAG_WIDTH, tag of the originating read.
REQ-019 SHALL have rsp_ready, input, 1, response accept.
REQ-020 SHALL have pending, output, log2(QUEUE_SIZE)+1, count of outstanding reads.

Function
REQ-021 A request SHALL fire when req_valid and req_ready are both high; a response SHALL fire when rsp_valid and rsp_ready are both high.
REQ-022 The storage index SHALL be req_addr[log2(DEPTH)-1:0]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH.
REQ-023 A write fire SHALL update each byte i with byteen[i]=1 at the next clock edge, SHALL produce no response and SHALL NOT change pending.
REQ-024 A read fire in cycle T SHALL read storage and enter a LATENCY-deep valid/data/tag pipeline.
REQ-025 With an empty response queue, rsp_valid SHALL assert in cycle T+LATENCY with the read data and req_tag.
REQ-026 On exit from the pipeline, each read result SHALL be written into a QUEUE_SIZE-entry first-word-fall-through FIFO.
REQ-027 rsp_valid, rsp_data and rsp_tag SHALL come from the FIFO head.
REQ-028 Responses SHALL be returned strictly in request order.
REQ-029 rsp_valid SHALL hold, and rsp_data and rsp_tag SHALL remain stable, while rsp_ready is low.
REQ-030 pending SHALL increment on a read fire and decrement on a response fire; on a read fire and response fire in the same cycle, pending SHALL remain unchanged.
REQ-031 req_ready SHALL equal (pending != QUEUE_SIZE).
REQ-032 req_ready SHALL be registered-state-derived only, with no combinational path from rsp_ready or req_valid.
REQ-033 While pending equals QUEUE_SIZE, writes SHALL also stall.
REQ-034 Credit accounting SHALL guarantee the FIFO never overflows; pipeline plus FIFO occupancy SHALL never exceed QUEUE_SIZE.
REQ-035 A read fire in cycle T+1 after a write fire to the same index in cycle T SHALL return the written data.
REQ-036 Sustained throughput SHALL be one read per cycle when rsp_ready is held high and QUEUE_SIZE is at least LATENCY+1.

Reset
REQ-037 On reset, pending SHALL be 0, all pipeline valid bits SHALL be 0, the FIFO SHALL be empty, rsp_valid SHALL be 0 and req_ready SHALL be 1 in the cycle after reset deasserts.
REQ-038 Reset mid-operation SHALL discard all in-flight reads and queued responses.
REQ-039 Storage contents SHALL NOT be affected by reset.
REQ-040 rsp_data and rsp_tag SHALL be don't-care while rsp_valid is 0.

Verification
REQ-041 (Write-then-read) Write addr 0x10 data 0xDEADBEEF byteen 1111, then next cycle read addr 0x10 tag 0x21 -> rsp_valid exactly 2 cycles after the read fire, with rsp_data 0xDEADBEEF and rsp_tag 0x21.
REQ-042 (Partial write and wrap) Write addr 0x5 data 0x11223344 byteen 1111, then write addr 0x405 data 0xAABBCCDD byteen 0011, then read addr 0x5 -> rsp_data 0x1122CCDD.
REQ-043 (Backpressure and full) Hold rsp_ready=0 and issue 5 back-to-back reads with tags 1..5 -> first 4 accepted, req_ready low from the cycle after the 4th fire, pending=4, rsp_tag held at 1; then raise rsp_ready -> tags 1,2,3,4 in order, 5th accepted the cycle after the first response fire, then tag 5.
REQ-044 (Simultaneous fire) With pending=4 and rsp_ready=1, one response fire per cycle while reads re-enter -> pending stays 3 or 4 and never exceeds 4; no response is lost or duplicated (scoreboard check).
REQ-045 (Reset mid-flight) Issue 3 reads, assert reset 1 cycle after the 3rd fire -> no rsp_valid after reset, pending=0, req_ready=1, and a read of addr 0x10 afterwards still returns 0xDEADBEEF.
REQ-046 (Streaming) 64 random reads with rsp_ready=1 and random tags -> one fire per cycle, in-order tags, data matching the reference model.
